// File: rtl/axixfer_pkg.sv
// Shared definitions for the axixfer transmit side.
//   - state_t      : burst source FSM states (GAP exists only with the
//                    AXIS_BURST_SOURCE_GAP_EN build option)
//   - N/LW/CW_DEF  : default data, length and burst-counter widths
//   - LFSR_SEED    : value loaded into the gap LFSR on reset
//   - LFSR_TAPS    : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
package axixfer_pkg;

    localparam int N_DEF  = 8;
    localparam int LW_DEF = 8;
    localparam int CW_DEF = 16;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/axis_burst_source_lfsr8.sv
// lfsr8: seeded 8-bit Fibonacci LFSR, shifts left with feedback into bit 0.
// Ports:
//   clock   in   posedge clock
//   reset   in   synchronous active-high, loads LFSR_SEED
//   i_en    in   advance one step this cycle
//   o_lfsr  out  current LFSR state
module lfsr8
    import axixfer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    output logic [7:0] o_lfsr
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = ^(r_lfsr & LFSR_TAPS);
    assign o_lfsr = r_lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule

// File: rtl/axis_burst_source.sv
// axis_burst_source: accepts a burst command (base, length) and emits
// CMD_LEN+1 incrementing data words on a valid/ready W channel, flagging
// the final beat with WLAST. Payload is held stable until accepted.
// Build option AXIS_BURST_SOURCE_GAP_EN: after each accepted non-last beat,
// an LFSR bit may insert a one-cycle bubble (GAP state).
// Ports:
//   clock, reset          posedge clock, synchronous active-high reset
//   CMD_VALID/CMD_READY   command handshake (ready only while IDLE)
//   CMD_BASE [N-1:0]      first data word
//   CMD_LEN  [LW-1:0]     beats minus one
//   WVALID/WREADY         data beat handshake
//   WDATA    [N-1:0]      beat payload, base+index modulo 2^N
//   WLAST                 final beat of the burst
//   BUSY                  burst in progress
//   BURSTS   [CW-1:0]     completed-burst count (wraps)
module axis_burst_source
    import axixfer_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
)
(
    input  logic          clock,
    input  logic          reset,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [N-1:0]  CMD_BASE,
    input  logic [LW-1:0] CMD_LEN,
    output logic          WVALID,
    input  logic          WREADY,
    output logic [N-1:0]  WDATA,
    output logic          WLAST,
    output logic          BUSY,
    output logic [CW-1:0] BURSTS
);

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_base;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_index;
    logic [CW-1:0] r_bursts;

    logic          w_is_last;
    logic          w_cmd_acc;
    logic          w_beat_acc;
    logic          w_gap_req;

    // Index is LW bits, same as the length, so index==len is always reached
    // before it could wrap, even for 2^LW-beat bursts.
    assign w_is_last  = (r_index == r_len);
    assign w_cmd_acc  = (r_state == IDLE) && CMD_VALID;
    assign w_beat_acc = (r_state == SEND) && WREADY;

`ifdef AXIS_BURST_SOURCE_GAP_EN
    logic [7:0] w_lfsr;

    lfsr8 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .i_en   (1'b1),
        .o_lfsr (w_lfsr)
    );

    assign w_gap_req = w_lfsr[0];
`else
    assign w_gap_req = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: the last-beat edge always returns to IDLE, so a new command
    // can only be taken on a later edge.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (CMD_VALID) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                if (WREADY) begin
                    if (w_is_last) begin
                        w_next = IDLE;
                    end else if (w_gap_req) begin
                        w_next = GAP;
                    end
                end
            end
            GAP:     w_next = SEND;
            default: w_next = IDLE;
        endcase
    end

    // Outputs depend on registered state only, never on WREADY.
    always_comb begin
        CMD_READY = (r_state == IDLE);
        BUSY      = (r_state != IDLE);
        WVALID    = (r_state == SEND);
        WLAST     = (r_state == SEND) && w_is_last;
        WDATA     = (r_state == SEND) ? (r_base + N'(r_index)) : '0;
    end

    assign BURSTS = r_bursts;

    // Command payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clock) begin
        if (w_cmd_acc) begin
            r_base <= CMD_BASE;
            r_len  <= CMD_LEN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_index <= '0;
        end else if (w_cmd_acc) begin
            r_index <= '0;
        end else if (w_beat_acc && !w_is_last) begin
            r_index <= r_index + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bursts <= '0;
        end else if (w_beat_acc && w_is_last) begin
            r_bursts <= r_bursts + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_burst_source.sv
module tb_axis_burst_source;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_base;
    logic [7:0]  cmd_len;
    logic        wvalid;
    logic        wready;
    logic [7:0]  wdata;
    logic        wlast;
    logic        busy;
    logic [15:0] bursts;

`ifdef AXIS_BURST_SOURCE_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    int         n_pass   = 0;
    int         n_total  = 0;
    int         bursts_m = 0;
    logic [7:0] lfsr_m;
    bit         found;

    axis_burst_source #(.N(8), .LW(8), .CW(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_BASE  (cmd_base),
        .CMD_LEN   (cmd_len),
        .WVALID    (wvalid),
        .WREADY    (wready),
        .WDATA     (wdata),
        .WLAST     (wlast),
        .BUSY      (busy),
        .BURSTS    (bursts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference gap generator: x^8+x^6+x^5+x^4+1 from seed A5, one step per clock.
    always @(posedge clock) begin
        if (reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // mode 0: WREADY=1, 1: random, 2: pattern 1,0,0, 3: three beats then stall until cycle 8
    task automatic run_burst(input logic [7:0] base, input logic [7:0] len, input int mode);
        logic [7:0] q_data[$];
        bit         q_last[$];
        bit         exp_gap;
        int         cyc;
        int         nacc;
        int         wait_n;
        for (int i = 0; i <= int'(len); i++) begin
            q_data.push_back(8'(int'(base) + i));
            q_last.push_back(i == int'(len));
        end
        wait_n = 0;
        while (!cmd_ready && wait_n < 50) begin
            tick;
            wait_n++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        tick;
        cmd_valid = 1'b0;
        exp_gap = 1'b0;
        cyc     = 0;
        nacc    = 0;
        while (q_data.size() > 0 && cyc < 3000) begin
            if (exp_gap) begin
                chk("gap_wvalid", wvalid, 0);
                exp_gap = 1'b0;
                wready  = 1'($urandom_range(0, 1));
                tick;
                cyc++;
                continue;
            end
            chk("wvalid", wvalid, 1);
            chk("wdata", wdata, q_data[0]);
            chk("wlast", wlast, q_last[0]);
            chk("busy_ready", {busy, cmd_ready}, 2'b10);
            case (mode)
                0:       wready = 1'b1;
                1:       wready = 1'($urandom_range(0, 1));
                2:       wready = (cyc % 3 == 0);
                default: wready = (nacc < 3) || (cyc >= 8);
            endcase
            if (wready) begin
                if (q_last[0]) bursts_m++;
                else           exp_gap = GAP_ON && lfsr_m[0];
                void'(q_data.pop_front());
                void'(q_last.pop_front());
                nacc++;
            end
            tick;
            cyc++;
        end
        chk("burst_within_budget", q_data.size(), 0);
        wready = 1'b0;
        chk("idle_wvalid", wvalid, 0);
        chk("idle_wlast", wlast, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("bursts", bursts, 16'(bursts_m));
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = 8'h00;
        cmd_len   = 8'h00;
        wready    = 1'b0;
        found     = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wlast", wlast, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bursts", bursts, 0);

        run_burst(8'h10, 8'd3, 0);
        run_burst(8'hFE, 8'd3, 3);

        // Single beat, then a second command held high across the burst.
        cmd_valid = 1'b1;
        cmd_base  = 8'h55;
        cmd_len   = 8'd0;
        tick;
        cmd_base = 8'h66;
        chk("b2b_first_vld", wvalid, 1);
        chk("b2b_first_data", wdata, 8'h55);
        chk("b2b_first_last", wlast, 1);
        chk("b2b_busy_ready", cmd_ready, 0);
        wready = 1'b1;
        tick;
        bursts_m++;
        wready = 1'b0;
        chk("b2b_gap_wvalid", wvalid, 0);
        chk("b2b_gap_ready", cmd_ready, 1);
        chk("b2b_bursts", bursts, 16'(bursts_m));
        tick;
        cmd_valid = 1'b0;
        chk("b2b_second_vld", wvalid, 1);
        chk("b2b_second_data", wdata, 8'h66);
        chk("b2b_second_last", wlast, 1);
        wready = 1'b1;
        tick;
        bursts_m++;
        wready = 1'b0;
        chk("b2b_end_wvalid", wvalid, 0);
        chk("b2b_end_bursts", bursts, 16'(bursts_m));

        run_burst(8'h20, 8'd7, 2);

        // Reset while beat 2 of a 6-beat burst is on offer.
        cmd_valid = 1'b1;
        cmd_base  = 8'h30;
        cmd_len   = 8'd5;
        tick;
        cmd_valid = 1'b0;
        wready    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (wvalid && wdata == 8'h32) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        chk("reach_beat2", found, 1);
        reset = 1'b1;
        tick;
        reset  = 1'b0;
        wready = 1'b0;
        bursts_m = 0;
        chk("abort_wvalid", wvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_bursts", bursts, 0);

        run_burst(8'h00, 8'd1, 0);
        run_burst(8'h40, 8'd15, 0);
        run_burst(8'h80, 8'd255, 0);
        for (int r = 0; r < 6; r++) begin
            run_burst(8'($urandom), 8'($urandom_range(0, 20)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_burst_source.md
Name: axis_burst_source

Overview:
- Transmit-side counterpart for the valid/ready FIFO write port in the axixfer example.
- Accepts a burst command (base value, length) and drives a W-channel stream of incrementing data words with a last-beat flag into a downstream receiver such as the 4-deep FIFO.
- Obeys source-side handshake rules (valid held, payload stable until accepted), so formal/SCY traces can cover FIFO full, back-pressure and wrap.

Parameters:
- N, 8, data width of WDATA and CMD_BASE.
- LW, 8, width of CMD_LEN; burst length = CMD_LEN+1 beats (1..2^LW).
- CW, 16, width of the completed-burst counter.

Ports:
- clock  input  1  clock, all state on posedge
- reset  input  1  synchronous, active-high reset
- CMD_VALID  input  1  burst command offered
- CMD_READY  output  1  source idle and able to accept a command
- CMD_BASE  input  N  first data word of burst
- CMD_LEN  input  LW  beats minus one
- WVALID  output  1  data beat offered downstream
- WREADY  input  1  downstream accepts beat
- WDATA  output  N  beat payload
- WLAST  output  1  final beat of burst
- BUSY  output  1  burst in progress (state != IDLE)
- BURSTS  output  CW  count of completed bursts

Behaviour:
- Clock and reset: reset, synchronous, active-high; clock clock.
- Reset values: state=IDLE, WVALID=0, WLAST=0, WDATA=0, CMD_READY=1 (combinational from state), BUSY=0, BURSTS=0, beat index=0.
- States: IDLE, SEND (plus GAP with the optional feature).
- IDLE: CMD_READY=1. On CMD_VALID&&CMD_READY, latch base and len, clear index, go to SEND.
  - WVALID rises the cycle after acceptance (1-cycle latency); WDATA=base.
- SEND:
  - WVALID=1, WDATA=base+index truncated mod 2^N (wrap allowed, no carry out), WLAST=(index==len).
- Handshake rules:
  - Once WVALID=1, WVALID, WDATA and WLAST hold stable until the cycle with WREADY=1.
  - WVALID never depends combinationally on WREADY.
- Beat accepted (WVALID&&WREADY) with WLAST=0: index++, next beat presented the following cycle (full throughput, 1 beat/cycle).
- Beat accepted with WLAST=1:
  - go to IDLE, WVALID=0 and WLAST=0 next cycle, BURSTS++ (wraps at 2^CW).
  - No command accepted on the same edge; minimum one IDLE cycle between bursts.
- CMD_LEN=0: single beat with WLAST=1 on the first beat.
- CMD_LEN=2^LW-1: 2^LW beats; the index counter is LW bits wide and must not overflow before WLAST.
- CMD_VALID while busy: ignored, CMD_READY=0; the command stays pending upstream.
- WREADY low indefinitely: source stalls in SEND, outputs frozen.
- Reset mid-burst: abort. Next cycle WVALID=0, state IDLE, BURSTS=0. No partial-burst completion count.

Optional Feature:
- Macro AXIS_BURST_SOURCE_GAP_EN.
- When defined:
  - 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every clock.
  - After each accepted non-last beat, if lfsr[0]==1, enter GAP for one cycle with WVALID=0, then return to SEND.
  - Gaps only follow a handshake, so WVALID never drops before acceptance.
- When undefined: no LFSR, no GAP state, WVALID continuous within a burst.

Decomposition:
- Package axixfer_pkg: state enum (IDLE, SEND, GAP), default widths N/LW/CW, LFSR seed and tap constants.
- Sub-module lfsr8 (seeded 8-bit LFSR with enable), instantiated only under AXIS_BURST_SOURCE_GAP_EN.
- Everything else stays in the top module.

Test Plan:
- Reset, then CMD base=8'h10, len=3, WREADY=1 constant -> CMD_READY drops for the burst; WDATA 10,11,12,13 on 4 consecutive cycles starting 1 cycle after accept; WLAST only on 13; BURSTS=1; CMD_READY=1 the cycle after the last beat.
- base=8'hFE, len=3 into the 4-deep FIFO with the reader stalled -> data FE,FF,00,01 wraps; 4th beat held while the FIFO is full (WREADY=0 after 3 writes); WDATA stable at 01 until the reader pops, then accepted.
- len=0, base=8'h55 -> single beat 55 with WLAST=1; back-to-back command with CMD_VALID held high is accepted only after the 1-cycle IDLE.
- WREADY toggling 1,0,0,1,... during len=7 burst -> no dropped or duplicated words; WVALID never falls before acceptance; 8 beats total.
- Reset asserted in beat 2 of a len=5 burst -> WVALID=0 next cycle; BURSTS=0; new command base=8'h00, len=1 yields 00,01.
- With AXIS_BURST_SOURCE_GAP_EN, len=15, WREADY=1 -> 16 beats, gaps match the LFSR sequence from seed A5, no gap after the WLAST beat.
